mod_loader: RTL and testbench

Bus initiator that loads a program image into a memory-mapped responder: RAM, or the ROM's inferred RAM during bring-up. It takes a byte stream, typically from the UART receiver, parses a header, and issues single-word writes on the data port (de/drw/daddr/din). It then reads the same range back through dout and compares 32-bit sums. It sits between the UART and the data-side bus mux and owns the bus only while busy is high.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/loader_shift.sv | 50 +++++
 rtl/mod_loader.sv | 142 ++++++++++++++
 tb/tb_mod_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// loader_pkg : shared state encoding and field sizes for the program loader
// Rev 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [3:0] {
        S_ADDR  = 4'd0,
        S_LEN   = 4'd1,
        S_DATA  = 4'd2,
        S_WRITE = 4'd3,
        S_VREAD = 4'd4,
        S_VCMP  = 4'd5,
        S_CHECK = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/loader_shift.sv
// ============================================================================
// loader_shift : big-endian byte-to-word assembler with position counter
// Rev 1.0
// ============================================================================
`default_nettype none

module loader_shift #(
    parameter int NBYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  rx_byte,
    output logic [31:0] value,
    output logic [31:0] value_nxt,
    output logic [1:0]  cnt,
    output logic        full
);

    logic [31:0] r_value;
    logic [1:0]  r_cnt;

    // value_nxt lets the parent act on a field in the same cycle its last byte lands
    always_comb begin
        value     = r_value;
        value_nxt = {r_value[23:0], rx_byte};
        cnt       = r_cnt;
        full      = en && (r_cnt == 2'(NBYTES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= '0;
            r_cnt   <= '0;
        end else begin
            if (en) begin
                r_value <= value_nxt;
            end
            if (clr || full) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mod_loader.sv
// ============================================================================
// mod_loader : streams a header + image onto the data bus, then verifies it
//              by summing a readback of the same range
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_loader
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        de,
    output logic        drw,
    output logic [31:0] daddr,
    output logic [31:0] din,
    input  logic [31:0] dout,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      r_state;
    logic [31:0] r_base;
    logic [31:0] r_count;
    logic [31:0] r_ptr;
    logic [31:0] r_rem;
    logic [31:0] r_wsum;
    logic [31:0] r_rsum;

    logic        w_fire;
    logic        w_asm_clr;
    logic [31:0] w_asm_value;
    logic [31:0] w_asm_nxt;
    logic [1:0]  w_asm_cnt;
    logic        w_asm_full;

    assign w_fire    = rx_valid && rx_ready;
    assign w_asm_clr = (r_state == S_DONE) || (r_state == S_ERR);

    // One assembler serves all three fields; the FSM decides where each result goes
    loader_shift #(
        .NBYTES (WORD_BYTES)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_asm_clr),
        .en        (w_fire),
        .rx_byte   (rx_data),
        .value     (w_asm_value),
        .value_nxt (w_asm_nxt),
        .cnt       (w_asm_cnt),
        .full      (w_asm_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_ADDR;
            r_base  <= '0;
            r_count <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_wsum  <= '0;
            r_rsum  <= '0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_asm_full) begin
                        r_base  <= align_word(w_asm_nxt);
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_asm_full) begin
                        r_count <= w_asm_nxt;
                        if (w_asm_nxt == 32'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_ptr   <= r_base;
                            r_rem   <= w_asm_nxt;
                            r_wsum  <= '0;
                            r_rsum  <= '0;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_asm_full) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_wsum <= r_wsum + w_asm_value;
                    if (r_rem == 32'd1) begin
                        r_ptr   <= r_base;
                        r_rem   <= r_count;
                        r_state <= S_VREAD;
                    end else begin
                        r_ptr   <= r_ptr + 32'd4;
                        r_rem   <= r_rem - 32'd1;
                        r_state <= S_DATA;
                    end
                end
                S_VREAD: begin
                    r_state <= S_VCMP;
                end
                S_VCMP: begin
                    r_rsum  <= r_rsum + dout;
                    r_ptr   <= r_ptr + 32'd4;
                    r_rem   <= r_rem - 32'd1;
                    r_state <= (r_rem == 32'd1) ? S_CHECK : S_VREAD;
                end
                S_CHECK: begin
                    r_state <= (r_wsum == r_rsum) ? S_DONE : S_ERR;
                end
                S_DONE, S_ERR: begin
                    r_state <= S_ADDR;
                end
                default: begin
                    r_state <= S_ADDR;
                end
            endcase
        end
    end

    always_comb begin
        rx_ready = (r_state == S_ADDR) || (r_state == S_LEN) || (r_state == S_DATA);
        de       = (r_state == S_WRITE) || (r_state == S_VREAD) || (r_state == S_VCMP);
        drw      = (r_state == S_WRITE);
        daddr    = de ? r_ptr : 32'd0;
        din      = (r_state == S_WRITE) ? w_asm_value : 32'd0;
        busy     = !((r_state == S_ADDR) && (w_asm_cnt == 2'd0));
        done     = (r_state == S_DONE);
        err      = (r_state == S_ERR);
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_loader.sv
// ============================================================================
// tb_mod_loader : scoreboard bench for mod_loader with a simple RAM responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mod_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        de;
    logic        drw;
    logic [31:0] daddr;
    logic [31:0] din;
    logic [31:0] dout = 32'h0;
    logic        busy;
    logic        done;
    logic        err;

    mod_loader dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .de       (de),
        .drw      (drw),
        .daddr    (daddr),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          tmo = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          done_cyc = 0;
    wr_t         exp_wr[$];
    wr_t         obs_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] obs_rd[$];
    logic [31:0] data_q[$];
    bit          last_rd = 0;
    logic [31:0] last_rd_addr = 0;
    bit          corrupt_en = 0;
    logic [31:0] corrupt_addr = 0;
    logic [31:0] mem [0:255];

    // Responder: write on de&drw, read data returned the following cycle
    always @(posedge clk) begin
        if (de && drw) mem[daddr[9:2]] <= din;
        if (de && !drw)
            dout <= mem[daddr[9:2]] ^ ((corrupt_en && daddr == corrupt_addr) ? 32'h1 : 32'h0);
    end

    // Monitor samples 1 time unit after each rising edge
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (de && drw) obs_wr.push_back({daddr, din});
        if (de && !drw) begin
            if (!last_rd || daddr != last_rd_addr) obs_rd.push_back(daddr);
            last_rd = 1;
            last_rd_addr = daddr;
        end else begin
            last_rd = 0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
    end

    task automatic clear_sb;
        exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
        done_cnt = 0; err_cnt = 0; tmo = 0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted
    task automatic send_byte(input logic [7:0] b, input bit first);
        int k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) begin
            tmo++;
        end else begin
            @(posedge clk);
            if (first) t0 = cyc;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd, input bit first);
        for (int i = 3; i >= 0; i--) begin
            if (rnd && $urandom_range(1, 0) == 1) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
            send_byte(w[i*8 +: 8], first && i == 3);
        end
    endtask

    // Pushes the expected bus traffic, then streams header and data_q
    task automatic load(input logic [31:0] base, input int n, input bit rnd);
        logic [31:0] p;
        p = {base[31:2], 2'b00};
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({p, data_q[i]});
            exp_rd.push_back(p);
            p = p + 32'd4;
        end
        send_word(base, rnd, 1'b1);
        send_word(32'(n), rnd, 1'b0);
        for (int i = 0; i < n; i++) send_word(data_q[i], rnd, 1'b0);
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        int k = 0;
        while (done_cnt + err_cnt == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt + err_cnt == 0) tmo++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        tests++; if ({de, drw, busy, done, err} !== 5'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 00000", {de, drw, busy, done, err}); end
        tests++; if ({daddr, din} !== 64'h0) begin fails++; $display("FAIL reset_bus: got %h want 0", {daddr, din}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        wr_t e, o;
        clear_sb();
        data_q = '{32'h11223344, 32'hAABBCCDD};
        load(32'h0000_0100, 2, 1'b0);
        wait_end(200);
        tests++; if (tmo !== 0) begin fails++; $display("FAIL basic_timeout: got %0d want 0", tmo); end
        tests++; if (obs_wr.size() !== 2) begin fails++; $display("FAIL basic_nwr: got %0d want 2", obs_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL basic_write: got %h want %h", o, e); end
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            tests++; if (obs_rd[0] !== exp_rd[0]) begin fails++; $display("FAIL basic_read: got %h want %h", obs_rd[0], exp_rd[0]); end
            void'(obs_rd.pop_front()); void'(exp_rd.pop_front());
        end
        tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL basic_pulses: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
        // done lands in cycle 8+5N+2N+2 counting the first header byte as cycle 1
        tests++; if (done_cyc - t0 !== 8 + 5*2 + 2*2 + 2 - 1) begin fails++; $display("FAIL basic_latency: got %0d want %0d", done_cyc - t0, 23); end
    endtask

    task automatic test_zero;
        clear_sb();
        data_q.delete();
        load(32'h0000_0080, 0, 1'b0);
        wait_end(50);
        tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL zero_pulses: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
        tests++; if (done_cyc - t0 !== 8) begin fails++; $display("FAIL zero_latency: got %0d want 8", done_cyc - t0); end
        tests++; if (obs_wr.size() + obs_rd.size() !== 0) begin fails++; $display("FAIL zero_bus: got %0d accesses want 0", obs_wr.size() + obs_rd.size()); end
    endtask

    task automatic test_corrupt;
        clear_sb();
        data_q = '{32'hCAFE0001, 32'h0BADF00D};
        corrupt_en = 1; corrupt_addr = 32'h0000_0044;
        load(32'h0000_0040, 2, 1'b0);
        wait_end(200);
        corrupt_en = 0;
        tests++; if (err_cnt !== 1 || done_cnt !== 0) begin fails++; $display("FAIL corrupt_pulses: got err=%0d done=%0d want 1/0", err_cnt, done_cnt); end
    endtask

    task automatic test_wrap;
        wr_t e, o;
        clear_sb();
        data_q = '{32'h01020304, 32'h05060708};
        load(32'hFFFF_FFFE, 2, 1'b0);
        wait_end(200);
        tests++; if (obs_wr.size() !== 2) begin fails++; $display("FAIL wrap_nwr: got %0d want 2", obs_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL wrap_write: got %h want %h", o, e); end
        end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random;
        wr_t e, o;
        clear_sb();
        data_q.delete();
        for (int i = 0; i < 6; i++) data_q.push_back($urandom);
        load(32'h0000_0200, 6, 1'b1);
        wait_end(300);
        tests++; if (tmo !== 0 || obs_wr.size() !== 6) begin fails++; $display("FAIL random_nwr: got %0d (tmo %0d) want 6", obs_wr.size(), tmo); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL random_write: got %h want %h", o, e); end
        end
        tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL random_pulses: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    endtask

    task automatic test_rst_mid;
        wr_t e, o;
        bit  prev = 0;
        bit  hit = 0;
        clear_sb();
        data_q = '{32'h10000001, 32'h20000002, 32'h30000003};
        load(32'h0000_0300, 3, 1'b0);
        for (int k = 0; k < 100 && !hit; k++) begin
            if (de && !drw && prev) hit = 1;
            else begin
                prev = de && !drw;
                @(negedge clk);
            end
        end
        tests++; if (!hit) begin fails++; $display("FAIL rstmid_vcmp: got no verify read want one"); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if ({de, busy, rx_ready} !== 3'b001) begin fails++; $display("FAIL rstmid_state: got de/busy/rdy=%b want 001", {de, busy, rx_ready}); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (done_cnt + err_cnt !== 0) begin fails++; $display("FAIL rstmid_abort: got %0d pulses want 0", done_cnt + err_cnt); end
        clear_sb();
        data_q = '{32'hDEADBEEF};
        load(32'h0000_0310, 1, 1'b0);
        wait_end(100);
        tests++; if (obs_wr.size() !== 1) begin fails++; $display("FAIL rstmid_nwr: got %0d want 1", obs_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL rstmid_write: got %h want %h", o, e); end
        end
        tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL rstmid_done: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero();
        test_corrupt();
        test_wrap();
        test_random();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
